// File: rtl/quant_pkg.sv
// Shared definitions for the quantizer sequencer: FSM states, block/ROM
// sizing and the JPEG zigzag scan table used when QUANT_ZIGZAG_EN is set.
package quant_pkg;

  localparam int unsigned BLK_C  = 64;
  localparam int unsigned ADDR_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_t;

  // Scan position -> raster ROM address (JPEG zigzag order).
  localparam logic [ADDR_W-1:0] ZZ_TAB [BLK_C] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  function automatic logic [ADDR_W-1:0] zz_addr(input logic [ADDR_W-1:0] idx);
    return ZZ_TAB[idx];
  endfunction

endpackage

// File: rtl/quant_zz_lut.sv
// Combinational zigzag lookup: scan index in, raster ROM address out.
// Only instantiated when QUANT_ZIGZAG_EN is defined.
module quant_zz_lut
  import quant_pkg::*;
(
  input  logic [ADDR_W-1:0] idx_i,
  output logic [ADDR_W-1:0] addr_o
);

  assign addr_o = zz_addr(idx_i);

endmodule

// File: rtl/quant_seq.sv
// Quantizer sequencer: accepts one 8x8 block of signed DCT coefficients,
// reads a reciprocal quant value from an external 1-cycle ROM per
// coefficient and emits rounded, saturated quantized coefficients two
// cycles after each transfer.
// Optional feature: define QUANT_ZIGZAG_EN to address the ROM in JPEG
// zigzag order instead of raster order.
module quant_seq
  import quant_pkg::*;
#(
  parameter int CW  = 12,
  parameter int BLK = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic signed [CW-1:0] coef_in,
  input  logic                 coef_valid,
  output logic                 coef_ready,
  output logic [ADDR_W-1:0]    rom_addr,
  input  logic [7:0]           rom_data,
  output logic signed [CW-1:0] q_out,
  output logic                 q_valid,
  output logic                 block_done,
  output logic                 busy
);

  localparam logic signed [CW+1:0] QMAX = (CW+2)'((2 ** (CW-1)) - 1);
  localparam logic signed [CW+1:0] QMIN = (CW+2)'(-(2 ** (CW-1)));

  state_t                 state_q, state_d;
  logic [ADDR_W-1:0]      idx_q, idx_d;
  logic [ADDR_W-1:0]      addr_q, addr_map;
  logic                   xfer;
  logic signed [CW-1:0]   s1_coef_q;
  logic                   s1_valid_q;
  logic signed [CW-1:0]   q_q, q_d;
  logic                   qv_q;
  logic                   done_q, done_d;

  logic signed [CW+8:0]   a_ext, b_ext, prod;
  logic signed [CW+9:0]   rnd;
  logic signed [CW+1:0]   shf;

  assign coef_ready = (state_q == ST_RUN);
  assign xfer       = coef_ready && coef_valid;

`ifdef QUANT_ZIGZAG_EN
  quant_zz_lut u_zz (
    .idx_i  (idx_q),
    .addr_o (addr_map)
  );
`else
  assign addr_map = idx_q;
`endif

  // Address follows idx only on a transfer; otherwise the last value is held.
  assign rom_addr   = xfer ? addr_map : addr_q;

  assign q_out      = q_q;
  assign q_valid    = qv_q;
  assign block_done = done_q;
  assign busy       = (state_q != ST_IDLE);

  // Control state, scan index and held ROM address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      addr_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= rom_addr;
      done_q  <= done_d;
    end
  end

  // Next-state: start in IDLE, count transfers in RUN, wait for last result in DRAIN.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (xfer) begin
          idx_d = idx_q + ADDR_W'(1);
          if (idx_q == ADDR_W'(BLK - 1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // The last coefficient sits in stage-1 now; its result and
        // block_done register together on this edge.
        if (s1_valid_q) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Stage-2 arithmetic: signed product, round-half-up, shift, saturate.
  always_comb begin
    a_ext = (CW+9)'(s1_coef_q);
    b_ext = (CW+9)'($signed({1'b0, rom_data}));
    prod  = a_ext * b_ext;
    rnd   = (CW+10)'(prod) + (CW+10)'(128);
    shf   = (CW+2)'(rnd >>> 8);
    q_d   = CW'(shf);
    if (shf > QMAX)      q_d = CW'(QMAX);
    else if (shf < QMIN) q_d = CW'(QMIN);
  end

  // Two-stage datapath: stage-1 holds the coefficient while the ROM reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_coef_q  <= '0;
      s1_valid_q <= 1'b0;
      q_q        <= '0;
      qv_q       <= 1'b0;
    end else begin
      s1_valid_q <= xfer;
      if (xfer) s1_coef_q <= coef_in;
      qv_q <= s1_valid_q;
      if (s1_valid_q) q_q <= q_d;
    end
  end

endmodule

// File: doc/quant_seq.md
QUANT_SEQ -- requirements
Module: quant_seq

Interface
REQ-001 SHALL have parameter CW, default 12: signed coefficient width, both input and output.
REQ-002 SHALL have parameter BLK, default 64: coefficients per block; fixed at 64 to match the 6-bit ROM address.
REQ-003 SHALL have ports, in this order:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin one 8x8 block.
- coef_in  in  CW  signed DCT coefficient.
- coef_valid  in  1  coef_in valid.
- coef_ready  out  1  block accepts coef_in.
- rom_addr  out  6  quant ROM address.
- rom_data  in  8  unsigned reciprocal quant value; valid one cycle after rom_addr.
- q_out  out  CW  signed quantized coefficient.
- q_valid  out  1  q_out valid.
- block_done  out  1  one-cycle pulse, coincident with the 64th q_valid.
- busy  out  1  high from start acceptance until block_done.

Function
REQ-004 SHALL implement FSM IDLE -> RUN -> DRAIN -> IDLE.
REQ-005 IDLE: when start=1, SHALL clear idx to 0, assert busy, and go to RUN on the next edge.
REQ-006 start SHALL be ignored outside IDLE.
REQ-007 RUN: coef_ready SHALL be 1, and a transfer SHALL occur when coef_valid && coef_ready.
REQ-008 On each transfer, rom_addr SHALL be driven combinationally from idx, coef_in SHALL be registered into stage-1, and idx SHALL increment.
REQ-009 On the transfer with idx=63, SHALL go to DRAIN; coef_ready SHALL be 0 in DRAIN and IDLE.
REQ-010 Stage-2 (cycle after stage-1) SHALL compute p = coef * {1'b0, rom_data} as a signed (CW+9)-bit product, then q = (p + 128) >>> 8, saturated to CW-bit signed range.
REQ-011 q_out/q_valid SHALL be registered: transfer at cycle t gives q_valid at t+2.
REQ-012 Gaps in coef_valid SHALL produce matching gaps in q_valid; ordering SHALL be preserved.
REQ-013 There SHALL be no downstream backpressure; the consumer always accepts.
REQ-014 DRAIN: block_done SHALL pulse with the q_valid for idx 63, and busy SHALL drop on that same edge (state -> IDLE).
REQ-015 start SHALL be accepted in the cycle immediately after block_done.
REQ-016 rom_addr SHALL hold its last value when no transfer occurs.

Reset
REQ-017 rst_n low SHALL asynchronously force: state=IDLE, idx=0, stage-1 valid=0, q_out=0, q_valid=0, block_done=0, busy=0, rom_addr=0.
REQ-018 Reset mid-block SHALL discard all in-flight coefficients with no partial block_done.
REQ-019 After rst_n deasserts, the block SHALL wait for a fresh start.

Configuration
REQ-020 Macro QUANT_ZIGZAG_EN: when defined, rom_addr SHALL equal zz(idx), the JPEG zigzag order (0,1,8,16,9,2,3,10,...,63), so coefficients arrive in zigzag order.
REQ-021 When QUANT_ZIGZAG_EN is undefined, rom_addr SHALL equal idx (raster order), and no zigzag logic SHALL be synthesized.

Structure
REQ-022 Package quant_pkg SHALL hold the FSM state enum, the BLK/ROM address-width constants, and the 64-entry zigzag table.
REQ-023 One sub-module, quant_zz_lut (6-bit idx in, 6-bit addr out, combinational), SHALL be instantiated only under QUANT_ZIGZAG_EN.
REQ-024 The ROM itself SHALL be external; it is not instantiated inside this block.

Verification
REQ-025 Bench SHALL model the ROM as a 1-cycle registered read of the team quant table.
REQ-026 Raster DC case: start, then coef_in=+1000 at idx 0 (rom=0xFF) -> q_out=996 with q_valid exactly 2 cycles after the transfer.
REQ-027 Negative rounding case: coef=-1000 with rom=0x80 -> q_out=-500; coef=+2047 with rom=0xFF -> q_out=2039.
REQ-028 Full block: 64 back-to-back transfers -> 64 q_valid, block_done on the 64th, busy low the next cycle, coef_ready low in DRAIN.
REQ-029 Gapped input: coef_valid toggled 1/0 -> q_valid pattern matches with 2-cycle offset; start pulsed mid-block is ignored.
REQ-030 rst_n pulsed low at idx 30 -> all outputs 0 immediately, no block_done; the following start runs a full 64-coefficient block.
REQ-031 Build with QUANT_ZIGZAG_EN: transfers idx 1, 2, 3 -> rom_addr 1, 8, 16.
REQ-032 Build without QUANT_ZIGZAG_EN: transfers idx 1, 2, 3 -> rom_addr 1, 2, 3.
